// File: rtl/partial_histogram_if.sv
// partial_histogram_if: pixel-in / packed-histogram-out handshake bundle
// slave : in_valid, in_mag, in_bin, out_ready in; in_ready, out_valid, partial_histogram, err_bin out
// master: mirror of slave
interface partial_histogram_if #(
   parameter int MAG_WIDTH = 8,
   parameter int OUT_WIDTH = 792
);
   logic                 in_valid;
   logic                 in_ready;
   logic [MAG_WIDTH-1:0] in_mag;
   logic [3:0]           in_bin;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] partial_histogram;
   logic                 err_bin;
   modport master (output in_valid, in_mag, in_bin, out_ready,
                   input  in_ready, out_valid, partial_histogram, err_bin);
   modport slave  (input  in_valid, in_mag, in_bin, out_ready,
                   output in_ready, out_valid, partial_histogram, err_bin);
endinterface

// File: rtl/partial_histogram_pack.sv
// partial_histogram_pack: accumulates a cell's pixels into per-row 9-bin partial histograms
// clk/rst: clock, sync active-high reset; bus (slave): pixel stream in, packed cell out
// PH_BIN_ERR_EN: when defined, err_bin flags accepted pixels with in_bin >= BINS (sticky)
module partial_histogram_pack #(
   parameter int MAG_WIDTH = 8,
   parameter int BIN_WIDTH = 11,
   parameter int BINS      = 9,
   parameter int CELL_ROWS = 8,
   parameter int CELL_COLS = 8
) (
   input logic               clk,
   input logic               rst,
   partial_histogram_if.slave bus
);
   localparam int OUT_WIDTH = BIN_WIDTH * BINS * CELL_ROWS;
   localparam int PIX       = CELL_ROWS * CELL_COLS;
   localparam int PW        = $clog2(PIX);
   localparam int RW        = $clog2(CELL_ROWS);
   localparam int IW        = $clog2(OUT_WIDTH);
   typedef enum logic {ACCUM, FLUSH} state_t;
   state_t               state, state_nxt;
   logic [PW-1:0]        pix_cnt;
   logic [OUT_WIDTH-1:0] acc, hist;
   logic                 out_valid, accept, last, xfer, bin_ok;
   logic [RW-1:0]        row;
   logic [IW-1:0]        idx;
   assign bus.in_ready          = state == ACCUM;
   assign bus.out_valid         = out_valid;
   assign bus.partial_histogram = hist;
   assign accept = bus.in_valid && bus.in_ready;
   assign last   = pix_cnt == PW'(PIX - 1);
   assign xfer   = state == FLUSH && (!out_valid || bus.out_ready);
   assign bin_ok = int'(bus.in_bin) < BINS;
   assign row    = RW'(pix_cnt / PW'(CELL_COLS));
   assign idx    = IW'(int'(row) * BINS * BIN_WIDTH + int'(bus.in_bin) * BIN_WIDTH);
   always_comb begin
      state_nxt = state;
      state_nxt = (state == ACCUM && accept && last) ? FLUSH : xfer ? ACCUM : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         pix_cnt   <= '0;
         acc       <= '0;
         hist      <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pix_cnt <= last ? '0 : pix_cnt + 1'b1;
            if (bin_ok) acc[idx +: BIN_WIDTH] <= acc[idx +: BIN_WIDTH] + BIN_WIDTH'(bus.in_mag);
         end
         // a transfer reloads the slot in the same cycle it is popped, so no bubble
         if (xfer) begin
            hist      <= acc;
            acc       <= '0;
            out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
`ifdef PH_BIN_ERR_EN
   logic err;
   assign bus.err_bin = err;
   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else if (accept && !bin_ok) err <= 1'b1;
   end
`else
   assign bus.err_bin = 1'b0;
`endif
endmodule

// File: tb/tb_partial_histogram_pack.sv
// tb_partial_histogram_pack: randomized self-checking bench for partial_histogram_pack
module tb_partial_histogram_pack;
   localparam int OW = 792;
   logic clk = 0, rst = 1;
   int   n_checks = 0, n_fail = 0;
   logic [7:0] pm [64];
   logic [3:0] pb [64];
   partial_histogram_if #(.MAG_WIDTH(8), .OUT_WIDTH(OW)) bus ();
   partial_histogram_pack dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   // expected cell: histogram of each 8-pixel row, bins >= 9 dropped, 11-bit wrap
   function automatic logic [OW-1:0] model();
      int h [8][9];
      logic [OW-1:0] v = '0;
      foreach (h[r, b]) h[r][b] = 0;
      for (int p = 0; p < 64; p++) if (pb[p] < 9) h[p / 8][pb[p]] += pm[p];
      for (int r = 0; r < 8; r++)
         for (int b = 0; b < 9; b++) v[r*99 + b*11 +: 11] = 11'(h[r][b] % 2048);
      return v;
   endfunction

   function automatic logic [10:0] fld(logic [OW-1:0] v, int r, int b);
      return v[r*99 + b*11 +: 11];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int cycles);
      rst = 1;
      bus.in_valid = 0;
      repeat (cycles) tick();
      rst = 0;
   endtask

   // feeds pixels 0..n-1; returns at #1 after the last accepting edge
   task automatic send(int n, bit gaps);
      for (int p = 0; p < n; p++) begin
         int t = 0;
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 0;
            bus.in_mag   = 8'($urandom);
            bus.in_bin   = 4'($urandom);
            tick();
         end
         while (!bus.in_ready && t < 200) begin tick(); t++; end
         if (!bus.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout pixel %0d: in_ready=0 required 1", p);
            bus.in_valid = 0;
            return;
         end
         bus.in_valid = 1;
         bus.in_mag   = pm[p];
         bus.in_bin   = pb[p];
         tick();
      end
      bus.in_valid = 0;
   endtask

   task automatic wait_out();
      for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_out: out_valid=%b required 1", bus.out_valid);
      end
   endtask

   task automatic check_cell(string name, logic [OW-1:0] exp);
      n_checks++;
      if (bus.partial_histogram !== exp) begin
         n_fail++;
         $display("FAIL %s: row0 got %h required %h", name, bus.partial_histogram[98:0], exp[98:0]);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      n_checks += 4;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: %b required 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: %b required 0", bus.out_valid); end
      if (bus.partial_histogram !== '0) begin n_fail++; $display("FAIL reset_hist: nonzero required 0"); end
      if (bus.err_bin !== 1'b0) begin n_fail++; $display("FAIL reset_err: %b required 0", bus.err_bin); end
   endtask

   task automatic test_all_ones();
      bus.out_ready = 1;
      for (int p = 0; p < 64; p++) begin pm[p] = 1; pb[p] = 0; end
      send(64, 0);
      n_checks += 2;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_lat1: out_valid=%b required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ones_flush_ready: in_ready=%b required 0", bus.in_ready); end
      tick();
      n_checks += 2;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_lat2: out_valid=%b required 1", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ones_ready_back: in_ready=%b required 1", bus.in_ready); end
      check_cell("ones_cell", model());
      for (int r = 0; r < 8; r++) begin
         n_checks++;
         if (fld(bus.partial_histogram, r, 0) !== 11'd8) begin
            n_fail++;
            $display("FAIL ones_row%0d_bin0: %0d required 8", r, fld(bus.partial_histogram, r, 0));
         end
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_pop: out_valid=%b required 0", bus.out_valid); end
   endtask

   task automatic test_max_mag();
      for (int p = 0; p < 64; p++) begin pm[p] = 255; pb[p] = 8; end
      send(64, 1);
      wait_out();
      check_cell("max_cell", model());
      for (int r = 0; r < 8; r++) begin
         n_checks++;
         if (bus.partial_histogram[r*99+88 +: 11] !== 11'h7F8) begin
            n_fail++;
            $display("FAIL max_row%0d_bin8: %h required 7f8", r, bus.partial_histogram[r*99+88 +: 11]);
         end
      end
      tick();
   endtask

   task automatic test_row_dep();
      for (int p = 0; p < 64; p++) begin pm[p] = 8'(p / 8 + 1); pb[p] = 4'(p / 8); end
      send(64, 1);
      wait_out();
      check_cell("rowdep_cell", model());
      for (int r = 0; r < 8; r++) begin
         n_checks++;
         if (fld(bus.partial_histogram, r, r) !== 11'(8 * (r + 1))) begin
            n_fail++;
            $display("FAIL rowdep_r%0d: %0d required %0d", r, fld(bus.partial_histogram, r, r), 8 * (r + 1));
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [OW-1:0] a_exp, b_exp;
      bus.out_ready = 0;
      for (int p = 0; p < 64; p++) begin pm[p] = 8'($urandom); pb[p] = 4'($urandom_range(0, 8)); end
      a_exp = model();
      send(64, 1);
      wait_out();
      for (int p = 0; p < 64; p++) begin pm[p] = 8'($urandom); pb[p] = 4'($urandom_range(0, 8)); end
      b_exp = model();
      send(64, 1);
      for (int i = 0; i < 5; i++) begin
         n_checks += 3;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: %b required 0", i, bus.in_ready); end
         if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: %b required 1", i, bus.out_valid); end
         if (bus.partial_histogram !== a_exp) begin n_fail++; $display("FAIL bp_hold_data c%0d: row0 %h required %h", i, bus.partial_histogram[98:0], a_exp[98:0]); end
         tick();
      end
      bus.out_ready = 1;
      tick();
      bus.out_ready = 0;
      n_checks += 2;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_swap_valid: %b required 1", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_swap_ready: %b required 1", bus.in_ready); end
      check_cell("bp_swap_data", b_exp);
      bus.out_ready = 1;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: %b required 0", bus.out_valid); end
   endtask

   task automatic test_invalid_bins();
      logic exp_err;
`ifdef PH_BIN_ERR_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      do_reset(2);
      bus.out_ready = 1;
      for (int p = 0; p < 64; p++) begin pm[p] = 1; pb[p] = 1; end
      pm[10] = 200; pb[10] = 9;
      pm[37] = 200; pb[37] = 15;
      send(11, 0);
      n_checks++;
      if (bus.err_bin !== exp_err) begin n_fail++; $display("FAIL inv_err_first: %b required %b", bus.err_bin, exp_err); end
      for (int p = 11; p < 64; p++) begin pm[p - 11] = pm[p]; pb[p - 11] = pb[p]; end
      send(53, 0);
      for (int p = 63; p >= 11; p--) begin pm[p] = pm[p - 11]; pb[p] = pb[p - 11]; end
      for (int p = 0; p < 11; p++) begin pm[p] = 1; pb[p] = 1; end
      pm[10] = 200; pb[10] = 9;
      wait_out();
      check_cell("inv_cell", model());
      n_checks += 3;
      if (fld(bus.partial_histogram, 1, 1) !== 11'd7) begin n_fail++; $display("FAIL inv_row1: %0d required 7", fld(bus.partial_histogram, 1, 1)); end
      if (fld(bus.partial_histogram, 4, 1) !== 11'd7) begin n_fail++; $display("FAIL inv_row4: %0d required 7", fld(bus.partial_histogram, 4, 1)); end
      if (bus.err_bin !== exp_err) begin n_fail++; $display("FAIL inv_err_sticky: %b required %b", bus.err_bin, exp_err); end
      tick();
   endtask

   task automatic test_mid_reset();
      for (int p = 0; p < 64; p++) begin pm[p] = 8'($urandom_range(1, 255)); pb[p] = 4'($urandom_range(0, 8)); end
      send(30, 1);
      do_reset(1);
      for (int p = 0; p < 64; p++) begin pm[p] = 1; pb[p] = 0; end
      send(64, 1);
      wait_out();
      check_cell("midrst_cell", model());
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 6; c++) begin
         for (int p = 0; p < 64; p++) begin pm[p] = 8'($urandom); pb[p] = 4'($urandom_range(0, 8)); end
         bus.out_ready = 1;
         send(64, 1);
         wait_out();
         check_cell($sformatf("rand_cell%0d", c), model());
         tick();
      end
   endtask

   initial begin
      bus.in_valid = 0;
      bus.in_mag = 0;
      bus.in_bin = 0;
      bus.out_ready = 0;
      test_reset();
      test_all_ones();
      test_max_mag();
      test_row_dep();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_invalid_bins();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
